cmd_target_regfile: RTL
=======================

// Module: cmd_target_regfile
// PURPOSE
//  Target (slave-side) end of the ready/valid command interface (WRITE/READ, address, data).
//  - Accepts commands from an initiator and services them against a local register bank.
//  - Returns READ data on a separate ready/valid response channel.
//  - Sits behind the slave modport wherever an initiator drives command transactions.
// PARAMETERS
//  ADDR_WIDTH  8   width of i_address
//  DATA_WIDTH  32  width of i_data / o_rsp_data
//  DEPTH       16  registers implemented (addresses 0..DEPTH-1); 1 <= DEPTH <= 2**ADDR_WIDTH
// PORTS
//  i_clk        in   1           clock, all logic on rising edge
//  i_rst        in   1           synchronous reset, active-high
//  i_valid      in   1           command valid
//  o_ready      out  1           target can accept a command
//  i_command    in   1           0 = WRITE, 1 = READ
//  i_address    in   ADDR_WIDTH  register address
//  i_data       in   DATA_WIDTH  write data (ignored for READ)
//  o_rsp_valid  out  1           read response valid
//  i_rsp_ready  in   1           response consumer ready
//  o_rsp_data   out  DATA_WIDTH  read data
//  o_rsp_err    out  1           response is for an out-of-range address
//  o_err_count  out  8           saturating count of out-of-range commands
// BEHAVIOUR
//  - Reset: one clock, synchronous and active-high; i_clk is the only clock.
//    - In any cycle with i_rst=1: state <= IDLE, all registers <= 0, o_err_count <= 0.
//    - Also: o_rsp_valid <= 0, o_rsp_data <= 0, o_rsp_err <= 0.
//    - o_ready is 0 while i_rst=1.
//    - Reset mid-response drops the pending response; it is never presented after reset.
//  - Command accept: a command is accepted in a cycle where i_valid && o_ready at the rising edge.
//  - o_ready = (state == IDLE) && !i_rst. Combinational from state; never from i_valid.
//  - The initiator holds the command stable while i_valid && !o_ready. The target does not check this.
//  - FSM states:
//    - IDLE: o_ready=1.
//      - Accepted WRITE: stays in IDLE.
//      - Accepted READ: goes to RESP.
//    - RESP: o_ready=0, o_rsp_valid=1.
//      - i_rsp_ready=1: goes to IDLE.
//      - Otherwise: stays in RESP, holding o_rsp_data and o_rsp_err stable.
//  - WRITE with i_address < DEPTH: reg[i_address] <= i_data at the accept edge.
//    - A new command can be accepted the next cycle.
//    - WRITE throughput is 1 per cycle.
//  - READ with i_address < DEPTH: at the accept edge, o_rsp_data <= reg[i_address] and o_rsp_err <= 0.
//    - o_rsp_valid rises the cycle after accept (latency 1).
//    - A READ accepted the cycle after a WRITE to the same address returns the new value.
//  - Out of range (i_address >= DEPTH):
//    - WRITE is dropped and no register changes.
//    - READ responds with o_rsp_data=0 and o_rsp_err=1.
//    - Both increment o_err_count, which saturates at 255 (no wrap).
//  - The response handshake completes when o_rsp_valid && i_rsp_ready.
//    - The minimum READ-to-READ interval is 2 cycles: accept, then respond with i_rsp_ready=1.
//    - The next accept is the cycle after the response handshake.
//  - Width rules:
//    - The address compare is unsigned at ADDR_WIDTH bits.
//    - Register index = i_address truncated to clog2(DEPTH) bits, used only when in range.
//  - X on i_command/i_address/i_data while i_valid=0 has no effect.
// TESTING
//  1. After reset: o_ready=1, o_rsp_valid=0, o_err_count=0.
//     - READ addr 5 -> 1 cycle later o_rsp_valid=1, data 0x00000000, err 0.
//  2. WRITE 0xDEADBEEF to addr 3, then READ addr 3 on the next cycle.
//     - Response data 0xDEADBEEF, err 0, 1 cycle after the READ accept.
//  3. READ addr 3 with i_rsp_ready=0 for 5 cycles.
//     - o_rsp_valid and o_rsp_data stay stable and o_ready=0 throughout.
//     - After i_rsp_ready=1: o_ready=1 on the next cycle.
//  4. DEPTH=16, WRITE 0x12345678 to addr 0x20, then READ addr 0x20.
//     - Response data 0, err 1; o_err_count=2.
//     - READ of addr 0x00 is unchanged, proving the write was dropped.
//  5. Issue 300 out-of-range commands -> o_err_count saturates at 255.
//  6. Reset during RESP with i_rsp_ready=0.
//     - o_rsp_valid=0 the cycle after the reset edge.
//     - A subsequent READ of a previously written addr returns 0.
//  7. Back-to-back WRITEs to addr 0..15 on 16 consecutive cycles with o_ready held 1.
//     - Reading each address returns its written value.

Source files
------------

// File: rtl/cmd_target_regfile.sv
// Slave end of the ready/valid command interface: services WRITE/READ commands
// against a local register bank and returns READ data on a response channel.
module cmd_target_regfile #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_command,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic [7:0]            o_err_count
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic        CMD_RD  = 1'b1;
  localparam logic [7:0]  ERR_MAX = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  accept;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  // Ready depends only on state and reset, never on i_valid.
  assign o_ready     = (state == IDLE) && !i_rst;
  assign o_rsp_valid = (state == RESP);
  assign accept      = i_valid && o_ready;

  // Extra MSB lets DEPTH == 2**ADDR_WIDTH compare correctly.
  assign in_range = {1'b0, i_address} < (ADDR_WIDTH + 1)'(DEPTH);
  assign idx      = i_address[IDX_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (i_command == CMD_RD)) state_next = RESP;
      RESP:    if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register bank: out-of-range writes are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (accept && (i_command != CMD_RD) && in_range) begin
      regs[idx] <= i_data;
    end
  end

  // Response payload captured at READ accept and held until handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_data <= '0;
      o_rsp_err  <= 1'b0;
    end else if (accept && (i_command == CMD_RD)) begin
      o_rsp_data <= in_range ? regs[idx] : '0;
      o_rsp_err  <= !in_range;
    end
  end

  // Saturating count of out-of-range commands of either kind.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_count <= '0;
    end else if (accept && !in_range && (o_err_count != ERR_MAX)) begin
      o_err_count <= o_err_count + 8'd1;
    end
  end

endmodule
